enter_input_frontend: RTL and testbench

- User-input producer for the processor's IN handshake: turns the raw DE1 pushbutton and the 8 slide switches into a clean (dataIn, enter) pair.
- Synchronises both inputs, debounces the key, and captures the switch byte on a debounced press.
- Holds enter high until the processor acknowledges the byte.
- Sits between board pins and the processor top's dataIn/enter inputs; ack is driven from the control unit's A-load during the input state.

---
 rtl/enter_input_frontend_if.sv | 24 ++
 rtl/enter_input_frontend.sv | 133 +++++++++++++
 tb/tb_enter_input_frontend.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/enter_input_frontend_if.sv
// Processor IN handshake: captured byte, byte-valid level, acknowledge and busy status.
// The frontend drives the master side; the processor's control unit uses the slave side.
interface enter_input_frontend_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  enter;
    logic                  ack;
    logic                  busy;

    modport master (
        output dataIn,
        output enter,
        output busy,
        input  ack
    );

    modport slave (
        input  dataIn,
        input  enter,
        input  busy,
        output ack
    );
endinterface

// File: rtl/enter_input_frontend.sv
// Pushbutton/slide-switch front end: synchronises the board inputs, debounces the key and
// presents one captured switch byte per debounced press on the enter/ack handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | key released; waiting for DEBOUNCE_CYCLES stable pressed samples
// PRESSED | single cycle; capture switches unless a byte is still pending
// HELD    | key down; waiting for DEBOUNCE_CYCLES stable released samples
module enter_input_frontend #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sw_in,
    input  logic                  key_n,
    enter_input_frontend_if.master bus
);

    if ((64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_WIDTH)) || (DEBOUNCE_CYCLES < 1)) begin : g_bad_cfg
        $error("enter_input_frontend: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_WIDTH-1");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    state_t                state_q, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_nxt;
    logic                  enter_q, enter_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;

    logic [1:0]            key_sync_q;
    logic [DATA_WIDTH-1:0] sw_s1_q, sw_s2_q;

    logic key_sync;
    logic expected_level;
    logic mismatch;
    logic stable;

    assign key_sync = key_sync_q[1];

    // Key chain resets to the released level so a key held through reset is seen as a new press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_sync_q <= 2'b11;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
        end else begin
            key_sync_q <= {key_sync_q[0], key_n};
            sw_s1_q    <= sw_in;
            sw_s2_q    <= sw_s1_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            enter_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            enter_q <= enter_nxt;
            data_q  <= data_nxt;
        end
    end

    // IDLE expects the released level (1); PRESSED/HELD expect the pressed level (0).
    always_comb begin
        expected_level = (state_q == IDLE);
        mismatch       = (key_sync != expected_level);
        stable         = mismatch && (cnt_q >= CNT_LAST);
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        enter_nxt = enter_q;
        data_nxt  = data_q;

        if (!mismatch) begin
            cnt_nxt = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_nxt = cnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (stable) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end
            end
            PRESSED: begin
                state_nxt = HELD;
                cnt_nxt   = '0;
                // Pre-edge enter decides: a pending byte blocks this capture.
                if (!enter_q) begin
                    enter_nxt = 1'b1;
                    data_nxt  = sw_s2_q;
                end
            end
            HELD: begin
                if (stable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (bus.ack && enter_q) begin
            enter_nxt = 1'b0;
        end
    end

    assign bus.dataIn = data_q;
    assign bus.enter  = enter_q;
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_enter_input_frontend.sv
// Directed bench for enter_input_frontend with DEBOUNCE_CYCLES=4; captures are scored by a
// monitor that pops expected byte and arrival cycle whenever enter rises.
module tb_enter_input_frontend;

    localparam int DW  = 8;
    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] sw_in = '0;
    logic          key_n = 1'b1;

    enter_input_frontend_if #(.DATA_WIDTH(DW)) bus ();

    enter_input_frontend #(
        .DATA_WIDTH      (DW),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_WIDTH       (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sw_in (sw_in),
        .key_n (key_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   rises  = 0;
    logic enter_prev = 1'b0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every rising enter must match the oldest expected capture.
    always @(negedge clock) begin
        if (reset) begin
            enter_prev = 1'b0;
        end else begin
            if (bus.enter && !enter_prev) begin
                rises++;
                if (sb.size() == 0) begin
                    chk("unexpected_enter", 32'(bus.dataIn), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("capture_data", 32'(bus.dataIn), 32'(e.data));
                    chk("capture_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_at_capture", 32'(bus.busy), 32'd1);
                end
            end
            enter_prev = bus.enter;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [DW-1:0] expect_data, input logic expect_capture);
        exp_t e;
        key_n = 1'b0;
        if (expect_capture) begin
            e.data = expect_data;
            e.cyc  = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
    endtask

    initial begin
        int r0;
        bus.ack = 1'b0;

        #1;
        chk("reset_dataIn", 32'(bus.dataIn), 32'h0);
        chk("reset_enter", 32'(bus.enter), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(3);

        // Bounce: toggle every 2 cycles for 30 cycles, never stable for 4 samples.
        for (int i = 0; i < 15; i++) begin
            key_n = ~key_n;
            tick(2);
        end
        key_n = 1'b1;
        tick(10);
        chk("bounce_enter", 32'(bus.enter), 32'h0);
        chk("bounce_busy", 32'(bus.busy), 32'h0);
        chk("bounce_dataIn", 32'(bus.dataIn), 32'h0);

        // Clean press A5, held 20 cycles, release 10 cycles.
        sw_in = 8'hA5;
        tick(3);
        press(8'hA5, 1'b1);
        tick(LAT - 1);
        chk("press_enter_early", 32'(bus.enter), 32'h0);
        tick(1);
        chk("press_enter", 32'(bus.enter), 32'h1);
        chk("press_busy", 32'(bus.busy), 32'h1);
        tick(20 - LAT);
        key_n = 1'b1;
        tick(10);
        chk("release_busy", 32'(bus.busy), 32'h0);
        chk("release_enter_kept", 32'(bus.enter), 32'h1);
        do_ack();
        chk("ack_a5_enter", 32'(bus.enter), 32'h0);
        chk("ack_a5_data", 32'(bus.dataIn), 32'hA5);

        // Ack handshake with 3C, then stray acks with enter low.
        sw_in = 8'h3C;
        tick(3);
        press(8'h3C, 1'b1);
        tick(12);
        key_n = 1'b1;
        tick(10);
        chk("pre_ack_enter", 32'(bus.enter), 32'h1);
        do_ack();
        chk("ack_enter", 32'(bus.enter), 32'h0);
        chk("ack_data", 32'(bus.dataIn), 32'h3C);
        do_ack();
        tick(1);
        do_ack();
        chk("stray_ack_enter", 32'(bus.enter), 32'h0);
        chk("stray_ack_data", 32'(bus.dataIn), 32'h3C);
        chk("stray_ack_busy", 32'(bus.busy), 32'h0);

        // Overrun: 11 pending, second press with 22 ignored, third press captures 22.
        sw_in = 8'h11;
        tick(3);
        press(8'h11, 1'b1);
        tick(12);
        key_n = 1'b1;
        tick(10);
        sw_in = 8'h22;
        tick(3);
        press(8'h22, 1'b0);
        tick(12);
        chk("overrun_busy", 32'(bus.busy), 32'h1);
        chk("overrun_enter", 32'(bus.enter), 32'h1);
        chk("overrun_data", 32'(bus.dataIn), 32'h11);
        key_n = 1'b1;
        tick(10);
        do_ack();
        chk("overrun_ack_enter", 32'(bus.enter), 32'h0);
        chk("overrun_ack_data", 32'(bus.dataIn), 32'h11);
        press(8'h22, 1'b1);
        tick(12);
        chk("third_data", 32'(bus.dataIn), 32'h22);
        key_n = 1'b1;
        tick(10);
        do_ack();

        // Long hold with switch drift after capture: exactly one enter.
        r0 = rises;
        sw_in = 8'h5A;
        tick(3);
        press(8'h5A, 1'b1);
        tick(10);
        for (int i = 0; i < 18; i++) begin
            sw_in = 8'(8'h5A ^ (i + 1));
            tick(5);
        end
        chk("hold_single_enter", 32'(rises - r0), 32'd1);
        chk("hold_data", 32'(bus.dataIn), 32'h5A);
        chk("hold_busy", 32'(bus.busy), 32'h1);
        key_n = 1'b1;
        tick(10);
        do_ack();

        // Mid-operation reset with key held and a byte pending.
        sw_in = 8'hC3;
        tick(3);
        press(8'hC3, 1'b1);
        tick(10);
        chk("midrst_pre_enter", 32'(bus.enter), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_enter", 32'(bus.enter), 32'h0);
        chk("midrst_data", 32'(bus.dataIn), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        tick(2);
        reset = 1'b0;
        press(8'hC3, 1'b1);
        tick(LAT + 2);
        chk("midrst_recapture", 32'(bus.dataIn), 32'hC3);
        key_n = 1'b1;
        tick(10);
        do_ack();
        tick(3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("total_captures", 32'(rises), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
